decode_scan_sequencer: RTL
==========================

# decode_scan_sequencer

Timed scan sequencer that drives the three select inputs (A, B, C) of the 3-to-8 decoder stage. It steps a row index from 0 to LAST_ROW and holds each row for a programmable dwell time. A drive-enable qualifies the decoder's one-hot output. An optional blanking gap between rows suppresses ghosting. It sits directly upstream of the decoder in the row-scan path.

## Interface
- DWELL, 16, cycles each row is driven (≥1)
- BLANK, 2, blank cycles between rows (≥1; used only with SCAN_BLANK_EN)
- LAST_ROW, 7, final row index of a frame (0..7)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin scanning (sampled in IDLE only)
- stop  in  1  request graceful stop (sampled while busy)
- A  out  1  row index bit 2 (MSB), to decoder
- B  out  1  row index bit 1, to decoder
- C  out  1  row index bit 0 (LSB), to decoder
- row_en  out  1  decoder output valid / row drive enable
- busy  out  1  high in any state except IDLE
- frame_done  out  1  one-cycle pulse at frame completion

## Operation
- States: IDLE, DRIVE, BLANK. BLANK exists only with SCAN_BLANK_EN.
- Reset values (all outputs registered): state=IDLE, {A,B,C}=000, row_en=0, busy=0, frame_done=0, timer=0, stop_pending=0.
- IDLE to DRIVE:
  - Occurs on the edge where start=1.
  - Index=0 and timer=0.
  - stop is ignored in IDLE. If start and stop are both high, start wins.
- DRIVE:
  - row_en=1 and the timer counts 0..DWELL-1.
  - On the edge where timer==DWELL-1:
    - If stop_pending: go to IDLE, index=0, row_en=0, stop_pending cleared.
    - Else if index==LAST_ROW: index wraps to 0 and frame_done=1 for one cycle.
    - Else: index+1.
    - Next state is BLANK with SCAN_BLANK_EN, otherwise DRIVE.
    - Timer restarts at 0.
- BLANK:
  - row_en=0 and the index already holds the new row, so the decoder settles while blanked.
  - The timer counts 0..BLANK-1, then returns to DRIVE.
  - stop_pending may be set during BLANK. It takes effect at the end of the following DRIVE row.
- stop while busy:
  - Sets stop_pending.
  - The current or next row completes its full dwell.
  - No frame_done is issued unless that row is LAST_ROW.
  - start is ignored while busy.
- Scanning runs continuously, frame after frame, until stopped.
- Timer width: $clog2 of the larger of DWELL and BLANK, plus 1. It is unsigned and never wraps beyond its terminal count.
- Index is 3 bits. Wrap is governed by LAST_ROW, not natural overflow.

## Timing
- Latency from start to row_en=1 with ABC=000: 1 cycle. This is the first cycle after the sampling edge.
- Row period: DWELL+BLANK cycles with blanking, DWELL without.
- Frame period: (LAST_ROW+1) × row period.
- Index change: on the same edge as row_en falls with blanking. On the dwell boundary edge without blanking, with row_en staying high.
- frame_done: coincides with the first cycle of the next BLANK or DRIVE of row 0.
- rst mid-scan: on the next edge, all outputs return to reset values and any pending stop is discarded.

## Configuration
- SCAN_BLANK_EN defined:
  - BLANK state present.
  - row_en drops for BLANK cycles at every row transition, including the wrap from LAST_ROW to 0.
- SCAN_BLANK_EN undefined:
  - No BLANK state and the BLANK parameter is ignored.
  - row_en is held continuously high while busy.

## Structure
- Shared package scan_pkg holds:
  - state enum (IDLE, DRIVE, BLANK)
  - ROW_W=3
  - default DWELL and BLANK constants
- Sub-module scan_dwell_timer:
  - Loadable terminal count, clear, and enable.
  - Emits a done pulse at terminal count.
  - Reused for both dwell and blank intervals.

## Test plan
All scenarios use DWELL=4, BLANK=2, LAST_ROW=7 unless noted.
1. Reset: hold rst 2 cycles -> ABC=000, row_en=0, busy=0, frame_done=0; start during rst is ignored.
2. Start pulse -> next cycle row_en=1, ABC=000, held 4 cycles; then row_en=0 for 2 cycles with ABC=001; then row_en=1 with ABC=001.
3. Free run -> index steps 0..7 and back to 0; frame_done pulses exactly once every 48 cycles, in the cycle ABC returns to 000.
4. stop asserted in cycle 2 of row 3 -> row 3 completes 4 dwell cycles, then IDLE with ABC=000, busy=0, no frame_done; start while busy has no effect.
5. rst asserted mid-row 5 -> next cycle all outputs 0; a later start restarts at row 0 with full dwell.
6. SCAN_BLANK_EN undefined -> row_en continuously 1 while busy, ABC increments every 4 cycles, frame_done every 32 cycles.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared types and constants for the decoder row-scan sequencer.
package scan_pkg;

    localparam int ROW_W     = 3;
    localparam int DWELL_DEF = 16;
    localparam int BLANK_DEF = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_BLANK
    } state_t;

endpackage

// File: rtl/decode_scan_sequencer_if.sv
// Control and decoder-select bundle between the scan sequencer and its controller.
interface decode_scan_sequencer_if;

    logic start;
    logic stop;
    logic A;
    logic B;
    logic C;
    logic row_en;
    logic busy;
    logic frame_done;

    modport master (
        output start, stop,
        input  A, B, C, row_en, busy, frame_done
    );

    modport slave (
        input  start, stop,
        output A, B, C, row_en, busy, frame_done
    );

endinterface

// File: rtl/scan_dwell_timer.sv
// Interval counter with loadable terminal count; wraps to 0 on the cycle it reports done.
module scan_dwell_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] tc,
    output logic         done
);

    logic [W-1:0] count;

    assign done = en && (count == tc);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= done ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/decode_scan_sequencer.sv
// Row-scan sequencer driving the 3-to-8 decoder selects with a per-row dwell.
// Define SCAN_BLANK_EN to insert a blanked gap between rows.
module decode_scan_sequencer
    import scan_pkg::*;
#(
    parameter int DWELL    = DWELL_DEF,
    parameter int BLANK    = BLANK_DEF,
    parameter int LAST_ROW = 7
) (
    input logic                     clk,
    input logic                     rst,
    decode_scan_sequencer_if.slave  bus
);

    localparam int TW = $clog2((DWELL > BLANK) ? DWELL : BLANK) + 1;
    localparam logic [TW-1:0]    DWELL_TC = TW'(DWELL - 1);
    localparam logic [ROW_W-1:0] LAST     = ROW_W'(LAST_ROW);
`ifdef SCAN_BLANK_EN
    localparam logic [TW-1:0]    BLANK_TC = TW'(BLANK - 1);
`endif

    state_t           state, state_n;
    logic [ROW_W-1:0] row, row_n;
    logic             en_q, en_n;
    logic             busy_q, busy_n;
    logic             fd_q, fd_n;
    logic             pend, pend_n;
    logic [TW-1:0]    tc;
    logic             t_done;

`ifdef SCAN_BLANK_EN
    assign tc = (state == S_BLANK) ? BLANK_TC : DWELL_TC;
`else
    assign tc = DWELL_TC;
`endif

    scan_dwell_timer #(.W(TW)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == S_IDLE),
        .en   (state != S_IDLE),
        .tc   (tc),
        .done (t_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            row    <= '0;
            en_q   <= 1'b0;
            busy_q <= 1'b0;
            fd_q   <= 1'b0;
            pend   <= 1'b0;
        end else begin
            state  <= state_n;
            row    <= row_n;
            en_q   <= en_n;
            busy_q <= busy_n;
            fd_q   <= fd_n;
            pend   <= pend_n;
        end
    end

    always_comb begin
        state_n = state;
        row_n   = row;
        en_n    = en_q;
        busy_n  = busy_q;
        fd_n    = 1'b0;
        pend_n  = pend;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_n = S_DRIVE;
                    row_n   = '0;
                    en_n    = 1'b1;
                    busy_n  = 1'b1;
                    pend_n  = 1'b0;
                end
            end
            S_DRIVE: begin
                pend_n = pend | bus.stop;
                if (t_done) begin
                    fd_n = (row == LAST);
                    if (pend) begin
                        state_n = S_IDLE;
                        row_n   = '0;
                        en_n    = 1'b0;
                        busy_n  = 1'b0;
                        pend_n  = 1'b0;
                    end else begin
                        // Next row index is presented while blanked so the decoder settles dark.
                        row_n = (row == LAST) ? '0 : row + 1'b1;
`ifdef SCAN_BLANK_EN
                        state_n = S_BLANK;
                        en_n    = 1'b0;
`endif
                    end
                end
            end
`ifdef SCAN_BLANK_EN
            S_BLANK: begin
                pend_n = pend | bus.stop;
                if (t_done) begin
                    state_n = S_DRIVE;
                    en_n    = 1'b1;
                end
            end
`endif
            default: state_n = S_IDLE;
        endcase
    end

    assign {bus.A, bus.B, bus.C} = row;
    assign bus.row_en            = en_q;
    assign bus.busy              = busy_q;
    assign bus.frame_done        = fd_q;

endmodule
